// File: rtl/hcsr04_measurement_scheduler_if.sv
// ---------------------------------------------------------------------------
// hcsr04_measurement_scheduler_if
// Groups the two handshakes that the ranging scheduler controls:
//   - echo measurer side : Meas_start_o (arm pulse), Meas_done_i / Meas_data_i
//   - UART side          : Data_available_o (strobe), Data_o (BCD distance)
// Modports:
//   master : the scheduler (drives arm pulse, strobe and distance)
//   slave  : the surrounding blocks (drive done pulse and measured distance)
// ---------------------------------------------------------------------------
interface hcsr04_measurement_scheduler_if #(
   parameter int DATA_W = 12
);
   logic              Meas_done_i;
   logic [DATA_W-1:0] Meas_data_i;
   logic              Meas_start_o;
   logic              Data_available_o;
   logic [DATA_W-1:0] Data_o;

   modport master (
      input  Meas_done_i, Meas_data_i,
      output Meas_start_o, Data_available_o, Data_o
   );

   modport slave (
      output Meas_done_i, Meas_data_i,
      input  Meas_start_o, Data_available_o, Data_o
   );
endinterface

// File: rtl/hcsr04_measurement_scheduler.sv
// ---------------------------------------------------------------------------
// hcsr04_measurement_scheduler
// Runs the HC-SR04 ranging loop: trigger pulse, arm echo measurement, wait for
// a result or a timeout, hand one 3-digit BCD distance to the UART, then hold
// off until the fixed-length UART message has left the wire.
// Ports:
//   Clk_i          system clock
//   Reset_i        synchronous, active-low reset
//   Enable_i       level, 1 = continuous periodic measurement
//   Single_shot_i  pulse, one measurement request (honoured only when idle)
//   bus            measurer/UART handshakes (master modport)
//   Trigger_o      HC-SR04 trigger pulse
//   Busy_o         1 whenever a measurement cycle is in progress
//   Timeout_cnt_o  number of echo timeouts, saturating at 255
// All outputs are registered.
// ---------------------------------------------------------------------------
module hcsr04_measurement_scheduler #(
   parameter int TRIG_CYCLES         = 500,
   parameter int ECHO_TIMEOUT_CYCLES = 1_500_000,
   parameter int UART_HOLD_CYCLES    = 416_640,
   parameter int PERIOD_CYCLES       = 3_000_000,
   parameter int CNT_W               = 24,
   parameter int DATA_W              = 12
) (
   input  logic                                  Clk_i,
   input  logic                                  Reset_i,
   input  logic                                  Enable_i,
   input  logic                                  Single_shot_i,
   hcsr04_measurement_scheduler_if.master        bus,
   output logic                                  Trigger_o,
   output logic                                  Busy_o,
   output logic [7:0]                            Timeout_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIGGER,
      S_WAIT_ECHO,
      S_SEND,
      S_HOLD,
      S_GAP
   } state_t;

   // Terminal counts: a state lasting N cycles leaves when state_cnt == N-1.
   localparam logic [CNT_W-1:0]  TRIG_LAST    = CNT_W'(TRIG_CYCLES - 1);
   localparam logic [CNT_W-1:0]  TIMEOUT_LAST = CNT_W'(ECHO_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]  HOLD_LAST    = CNT_W'(UART_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]  PERIOD_LAST  = CNT_W'(PERIOD_CYCLES - 1);
   localparam logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(12'h999);

   function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   function automatic logic [7:0] sat_inc_8(input logic [7:0] v);
      return (&v) ? v : v + 8'd1;
   endfunction

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    state_cnt_q, state_cnt_d;
   logic [CNT_W-1:0]    period_cnt_q, period_cnt_d;
   logic [DATA_W-1:0]   data_q, data_d;
   logic [7:0]          tcnt_q, tcnt_d;
   logic                trigger_q, trigger_d;
   logic                meas_start_q, meas_start_d;
   logic                dav_q, dav_d;
   logic                busy_q, busy_d;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      tcnt_d  = tcnt_q;

      case (state_q)
         S_IDLE: begin
            if (Enable_i || Single_shot_i) state_d = S_TRIGGER;
         end
         S_TRIGGER: begin
            if (state_cnt_q == TRIG_LAST) state_d = S_WAIT_ECHO;
         end
         S_WAIT_ECHO: begin
            // A result arriving on the timeout cycle still counts as a result.
            if (bus.Meas_done_i) begin
               data_d  = bus.Meas_data_i;
               state_d = S_SEND;
            end else if (state_cnt_q == TIMEOUT_LAST) begin
               data_d  = TIMEOUT_DATA;
               tcnt_d  = sat_inc_8(tcnt_q);
               state_d = S_SEND;
            end
         end
         S_SEND: begin
            state_d = S_HOLD;
         end
         S_HOLD: begin
            if (state_cnt_q == HOLD_LAST) state_d = S_GAP;
         end
         S_GAP: begin
            // >= so that an overrun period retriggers on the next edge.
            if (!Enable_i)                       state_d = S_IDLE;
            else if (period_cnt_q >= PERIOD_LAST) state_d = S_TRIGGER;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      state_cnt_d  = (state_d != state_q) ? '0 : state_cnt_q + CNT_W'(1);
      period_cnt_d = (state_d == S_TRIGGER && state_q != S_TRIGGER) ? '0
                                                                     : sat_inc_cnt(period_cnt_q);

      // Outputs are decoded from the next state so they register with it.
      trigger_d    = (state_d == S_TRIGGER);
      meas_start_d = (state_q == S_TRIGGER) && (state_d == S_WAIT_ECHO);
      dav_d        = (state_d == S_SEND);
      busy_d       = (state_d != S_IDLE);
   end

   always_ff @(posedge Clk_i) begin
      if (!Reset_i) begin
         state_q      <= S_IDLE;
         state_cnt_q  <= '0;
         period_cnt_q <= '0;
         data_q       <= '0;
         tcnt_q       <= '0;
         trigger_q    <= 1'b0;
         meas_start_q <= 1'b0;
         dav_q        <= 1'b0;
         busy_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         state_cnt_q  <= state_cnt_d;
         period_cnt_q <= period_cnt_d;
         data_q       <= data_d;
         tcnt_q       <= tcnt_d;
         trigger_q    <= trigger_d;
         meas_start_q <= meas_start_d;
         dav_q        <= dav_d;
         busy_q       <= busy_d;
      end
   end

   assign Trigger_o            = trigger_q;
   assign Busy_o               = busy_q;
   assign Timeout_cnt_o        = tcnt_q;
   assign bus.Meas_start_o     = meas_start_q;
   assign bus.Data_available_o = dav_q;
   assign bus.Data_o           = data_q;

endmodule

// File: tb/tb_hcsr04_measurement_scheduler.sv
// ---------------------------------------------------------------------------
// tb_hcsr04_measurement_scheduler
// Directed stimulus with a strobe scoreboard: each request pushes the expected
// distance, timeout count and strobe cycle; a negedge monitor pops and compares
// whenever Data_available_o is seen.
// Parameters: TRIG=4, TIMEOUT=20, HOLD=10, PERIOD=60.
// ---------------------------------------------------------------------------
module tb_hcsr04_measurement_scheduler;

   localparam int TRIG    = 4;
   localparam int TIMEOUT = 20;
   localparam int HOLD    = 10;
   localparam int PERIOD  = 60;

   logic       Clk_i = 1'b0;
   logic       Reset_i;
   logic       Enable_i;
   logic       Single_shot_i;
   logic       Trigger_o;
   logic       Busy_o;
   logic [7:0] Timeout_cnt_o;

   hcsr04_measurement_scheduler_if #(.DATA_W(12)) bus ();

   hcsr04_measurement_scheduler #(
      .TRIG_CYCLES(TRIG), .ECHO_TIMEOUT_CYCLES(TIMEOUT), .UART_HOLD_CYCLES(HOLD),
      .PERIOD_CYCLES(PERIOD), .CNT_W(24), .DATA_W(12)
   ) dut (
      .Clk_i(Clk_i), .Reset_i(Reset_i), .Enable_i(Enable_i),
      .Single_shot_i(Single_shot_i), .bus(bus), .Trigger_o(Trigger_o),
      .Busy_o(Busy_o), .Timeout_cnt_o(Timeout_cnt_o)
   );

   always #5 Clk_i = ~Clk_i;

   int cyc = 0;
   always @(posedge Clk_i) cyc <= cyc + 1;

   typedef struct {
      logic [11:0] data;
      logic [7:0]  tcnt;
      int          at;
   } exp_t;

   exp_t       sb_q[$];
   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_tcnt;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   // Scoreboard monitor.
   always @(negedge Clk_i) begin
      if (Reset_i === 1'b1 && bus.Data_available_o === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_strobe", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("strobe_data", bus.Data_o, e.data);
            check("strobe_tcnt", Timeout_cnt_o, e.tcnt);
            check("strobe_cycle", cyc, e.at);
         end
      end
   end

   task automatic tick();
      @(posedge Clk_i);
      #1;
   endtask

   task automatic tick_to(input int target);
      while (cyc < target) tick();
   endtask

   // One single-shot measurement. Trigger rises in cycle c0+1, Meas_start in
   // cycle c0+5; done driven in cycle ms+off gives the strobe in ms+off+1.
   task automatic run_single(input bit use_done, input int off, input logic [11:0] din,
                             input logic [11:0] dexp, input bit hold_poke);
      int   c0, ms, s, w;
      exp_t e;
      c0 = cyc;
      ms = c0 + 1 + TRIG;
      s  = use_done ? ms + off + 1 : ms + TIMEOUT;
      if (!use_done) exp_tcnt = (exp_tcnt == 8'd255) ? 8'd255 : exp_tcnt + 8'd1;
      e.data = dexp; e.tcnt = exp_tcnt; e.at = s;
      sb_q.push_back(e);

      Single_shot_i = 1'b1;
      tick();
      Single_shot_i = 1'b0;
      check("trig_start", Trigger_o, 1'b1);
      check("busy_start", Busy_o, 1'b1);
      w = 0;
      while (Trigger_o === 1'b1 && w < 50) begin
         w++;
         tick();
      end
      check("trig_width", w, TRIG);
      check("meas_start", bus.Meas_start_o, 1'b1);
      tick();
      check("meas_start_width", bus.Meas_start_o, 1'b0);

      if (use_done) begin
         tick_to(ms + off);
         bus.Meas_done_i = 1'b1;
         bus.Meas_data_i = din;
         tick();
         bus.Meas_done_i = 1'b0;
         bus.Meas_data_i = 12'h000;
      end

      tick_to(s + 3);
      if (hold_poke) begin
         Single_shot_i   = 1'b1;
         bus.Meas_done_i = 1'b1;
         bus.Meas_data_i = 12'h777;
         tick();
         Single_shot_i   = 1'b0;
         bus.Meas_done_i = 1'b0;
         bus.Meas_data_i = 12'h000;
      end
      tick_to(s + 5);
      check("data_hold", bus.Data_o, dexp);
      tick_to(s + HOLD + 1);
      check("busy_gap", Busy_o, 1'b1);
      tick();
      check("busy_idle", Busy_o, 1'b0);
      repeat (5) tick();
      check("no_retrigger", Trigger_o, 1'b0);
   endtask

   // Three periods in continuous mode; Enable drops during the third WAIT_ECHO.
   task automatic run_continuous();
      int   c0, rel, nrise;
      int   rises[4];
      logic prev;
      exp_t e;
      c0 = cyc;
      for (int k = 0; k < 3; k++) begin
         e.data = 12'((k + 1) << 8);
         e.tcnt = exp_tcnt;
         e.at   = c0 + 11 + PERIOD * k;
         sb_q.push_back(e);
      end
      for (int k = 0; k < 4; k++) rises[k] = 0;
      nrise    = 0;
      prev     = 1'b0;
      Enable_i = 1'b1;
      for (int i = 0; i < 200; i++) begin
         tick();
         rel = cyc - c0;
         if (Trigger_o === 1'b1 && prev !== 1'b1) begin
            if (nrise < 4) rises[nrise] = rel;
            nrise++;
         end
         prev = Trigger_o;
         bus.Meas_done_i = (rel == 10 || rel == 70 || rel == 130);
         bus.Meas_data_i = bus.Meas_done_i ? 12'((rel / PERIOD + 1) << 8) : 12'h000;
         if (rel == 127) Enable_i = 1'b0;
      end
      bus.Meas_done_i = 1'b0;
      bus.Meas_data_i = 12'h000;
      check("cont_rise_count", nrise, 3);
      check("cont_first_rise", rises[0], 1);
      check("cont_period_1", rises[1] - rises[0], PERIOD);
      check("cont_period_2", rises[2] - rises[1], PERIOD);
      check("cont_idle_busy", Busy_o, 1'b0);
   endtask

   initial begin
      Reset_i         = 1'b0;
      Enable_i        = 1'b0;
      Single_shot_i   = 1'b0;
      bus.Meas_done_i = 1'b0;
      bus.Meas_data_i = 12'h000;
      exp_tcnt        = 8'd0;

      repeat (3) tick();
      check("rst_trigger", Trigger_o, 1'b0);
      check("rst_meas_start", bus.Meas_start_o, 1'b0);
      check("rst_dav", bus.Data_available_o, 1'b0);
      check("rst_busy", Busy_o, 1'b0);
      check("rst_tcnt", Timeout_cnt_o, 8'd0);
      check("rst_data", bus.Data_o, 12'h000);
      Reset_i = 1'b1;
      tick();

      run_single(1'b1, 5, 12'h123, 12'h123, 1'b0);
      check("tcnt_after_normal", Timeout_cnt_o, 8'd0);

      run_single(1'b1, TIMEOUT - 1, 12'h045, 12'h045, 1'b0);
      check("tcnt_done_at_timeout", Timeout_cnt_o, 8'd0);

      run_single(1'b0, 0, 12'h000, 12'h999, 1'b0);
      check("tcnt_after_timeout", Timeout_cnt_o, 8'd1);

      run_single(1'b1, 5, 12'h321, 12'h321, 1'b1);

      run_continuous();

      for (int i = 0; i < 300; i++) run_single(1'b0, 0, 12'h000, 12'h999, 1'b0);
      check("tcnt_saturated", Timeout_cnt_o, 8'd255);

      // Reset during the second trigger cycle.
      Single_shot_i = 1'b1;
      tick();
      Single_shot_i = 1'b0;
      tick();
      check("pre_rst_trigger", Trigger_o, 1'b1);
      Reset_i = 1'b0;
      tick();
      check("midrst_trigger", Trigger_o, 1'b0);
      check("midrst_meas_start", bus.Meas_start_o, 1'b0);
      check("midrst_dav", bus.Data_available_o, 1'b0);
      check("midrst_busy", Busy_o, 1'b0);
      check("midrst_tcnt", Timeout_cnt_o, 8'd0);
      check("midrst_data", bus.Data_o, 12'h000);
      Reset_i  = 1'b1;
      exp_tcnt = 8'd0;
      tick();
      check("post_rst_idle", Trigger_o, 1'b0);
      run_single(1'b1, 3, 12'h042, 12'h042, 1'b0);

      check("scoreboard_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
